// File: rtl/ob_cn_alloc.sv
// ob_cn_alloc: slot allocator and sequencer for the N-entry conditional-command table.
// Installs commands into the lowest free entry, retires entries on maturity or cancel,
// and drains the whole table one entry per cycle on a flush request.
// Optional feature macro: OB_CN_ALLOC_AFULL_EN adds the AFULL parameter and afull_r output.
//
// Handshake: an install happens in the cycle where cmd_vld_r and cmd_rdy are both high;
// cmd_rdy never depends on cmd_vld_r, and the allocate strobe al_vld is asserted only in
// that cycle. Retire/cancel/flush produce dl_vld strobes in the cycle they take effect.
module ob_cn_alloc #(
    parameter int N = 4
`ifdef OB_CN_ALLOC_AFULL_EN
    ,
    parameter int AFULL = N - 1
`endif
    ,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_vld_r,
    output logic         cmd_rdy,
    output logic [N-1:0] al_vld,
    input  logic         mtr_vld_r,
    input  logic         mtr_accept,
    input  logic [N-1:0] mtr_gnt,
    input  logic         cncl_vld,
    input  logic [W-1:0] cncl_slot,
    input  logic         flush_req,
    output logic [N-1:0] dl_vld,
    output logic [N-1:0] busy_r,
    output logic [W:0]   cnt_r,
    output logic         full_r,
    output logic         empty_r,
    output logic         flush_done_r,
    output logic         cncl_err_r,
`ifdef OB_CN_ALLOC_AFULL_EN
    output logic         afull_r,
`endif
    output logic [1:0]   state_dbg
);

    // Padded width so any cncl_slot value indexes a real bit (padding bits read as free).
    localparam int NP = 1 << W;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [N-1:0] free_pick;
    logic [N-1:0] busy_pick;
    logic [NP-1:0] busy_pad;
    logic [N-1:0] retire_vec;
    logic [N-1:0] cncl_vec;
    logic         cncl_hit;
    logic [N-1:0] busy_w;
    logic [W:0]   cnt_w;

    function automatic logic [W:0] popcount(input logic [N-1:0] v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + (W+1)'(v[i]);
        return c;
    endfunction

    assign busy_pad  = NP'(busy_r);
    assign state_dbg = state;

    // Priority pickers: lowest free slot for installs, lowest busy slot for the flush drain.
    always_comb begin
        logic found_free;
        logic found_busy;
        free_pick  = '0;
        busy_pick  = '0;
        found_free = 1'b0;
        found_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found_free && !busy_r[i]) begin
                free_pick[i] = 1'b1;
                found_free   = 1'b1;
            end
            if (!found_busy && busy_r[i]) begin
                busy_pick[i] = 1'b1;
                found_busy   = 1'b1;
            end
        end
    end

    // Strobes and next-state values; retire is masked to busy slots so the count stays exact.
    always_comb begin
        cmd_rdy    = (state == RUN) && !full_r;
        al_vld     = (cmd_vld_r && cmd_rdy) ? free_pick : '0;
        retire_vec = (mtr_vld_r && mtr_accept) ? (mtr_gnt & busy_r) : '0;
        cncl_hit   = cncl_vld && busy_pad[cncl_slot];
        cncl_vec   = cncl_hit ? (N'(1) << cncl_slot) : '0;
        dl_vld     = retire_vec | cncl_vec | ((state == FLUSH) ? busy_pick : '0);
        busy_w     = (busy_r & ~dl_vld) | al_vld;
        cnt_w      = cnt_r + (W+1)'(|al_vld) - popcount(dl_vld);
    end

    // Flush sequencer next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (flush_req) state_nx = FLUSH;
            FLUSH:   if ((busy_r & ~dl_vld) == '0) state_nx = DONE;
            DONE:    state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // State register plus busy map, count and flags, all updated together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            busy_r       <= '0;
            cnt_r        <= '0;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            flush_done_r <= 1'b0;
            cncl_err_r   <= 1'b0;
        end else begin
            state        <= state_nx;
            busy_r       <= busy_w;
            cnt_r        <= cnt_w;
            full_r       <= (cnt_w == (W+1)'(N));
            empty_r      <= (cnt_w == '0);
            flush_done_r <= (state_nx == DONE);
            if (cncl_vld && !cncl_hit) cncl_err_r <= 1'b1;
        end
    end

`ifdef OB_CN_ALLOC_AFULL_EN
    // Almost-full flag tracks the next count so it lines up with cnt_r.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) afull_r <= 1'b0;
        else      afull_r <= (cnt_w >= (W+1)'(AFULL));
    end
`endif

endmodule

// File: tb/tb_ob_cn_alloc.sv
// tb_ob_cn_alloc: directed scenarios plus a randomized phase for ob_cn_alloc (N=4).
module tb_ob_cn_alloc;

    localparam int N = 4;
    localparam int W = 2;
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic         clk;
    logic         rst;
    logic         cmd_vld_r;
    logic         cmd_rdy;
    logic [N-1:0] al_vld;
    logic         mtr_vld_r;
    logic         mtr_accept;
    logic [N-1:0] mtr_gnt;
    logic         cncl_vld;
    logic [W-1:0] cncl_slot;
    logic         flush_req;
    logic [N-1:0] dl_vld;
    logic [N-1:0] busy_r;
    logic [W:0]   cnt_r;
    logic         full_r;
    logic         empty_r;
    logic         flush_done_r;
    logic         cncl_err_r;
    logic [1:0]   state_dbg;
`ifdef OB_CN_ALLOC_AFULL_EN
    logic         afull_r;
`endif

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    ob_cn_alloc #(.N(N)) dut (
        .clk(clk), .rst(rst), .cmd_vld_r(cmd_vld_r), .cmd_rdy(cmd_rdy), .al_vld(al_vld),
        .mtr_vld_r(mtr_vld_r), .mtr_accept(mtr_accept), .mtr_gnt(mtr_gnt),
        .cncl_vld(cncl_vld), .cncl_slot(cncl_slot), .flush_req(flush_req),
        .dl_vld(dl_vld), .busy_r(busy_r), .cnt_r(cnt_r), .full_r(full_r),
        .empty_r(empty_r), .flush_done_r(flush_done_r), .cncl_err_r(cncl_err_r),
`ifdef OB_CN_ALLOC_AFULL_EN
        .afull_r(afull_r),
`endif
        .state_dbg(state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        cmd_vld_r  = 1'b0;
        mtr_vld_r  = 1'b0;
        mtr_accept = 1'b0;
        mtr_gnt    = '0;
        cncl_vld   = 1'b0;
        cncl_slot  = '0;
        flush_req  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Checks a pop from exp_q against an observed strobe vector.
    task automatic pop_check(input string name, input logic [N-1:0] got);
        logic [N-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %b, expected queue empty", name, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %b required %b", name, got, e);
            end
        end
    endtask

    // Install count installs back-to-back, then idle.
    task automatic install_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idle_inputs();
            cmd_vld_r = 1'b1;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #12;
        checks++;
        if ({busy_r, cnt_r, full_r, empty_r, flush_done_r, cncl_err_r} !== {4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_regs: busy=%b cnt=%0d full=%b empty=%b done=%b err=%b required 0000 0 0 1 0 0",
                     busy_r, cnt_r, full_r, empty_r, flush_done_r, cncl_err_r);
        end
        checks++;
        if ({al_vld, dl_vld, cmd_rdy, state_dbg} !== {4'b0000, 4'b0000, 1'b1, S_RUN}) begin
            errors++;
            $display("FAIL reset_comb: al=%b dl=%b rdy=%b state=%0d required 0000 0000 1 0",
                     al_vld, dl_vld, cmd_rdy, state_dbg);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill();
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_vld_r = 1'b1;
            #1;
            pop_check($sformatf("fill_al_%0d", i), al_vld);
`ifdef OB_CN_ALLOC_AFULL_EN
            checks++;
            if (afull_r !== (i >= 3)) begin
                errors++;
                $display("FAIL fill_afull_%0d: got %b required %b", i, afull_r, (i >= 3));
            end
`endif
        end
        checks++;
        if ({busy_r, cnt_r, full_r, empty_r, cmd_rdy} !== {4'b1111, 3'd4, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fill_state: busy=%b cnt=%0d full=%b empty=%b rdy=%b required 1111 4 1 0 0",
                     busy_r, cnt_r, full_r, empty_r, cmd_rdy);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_hole_reuse();
        @(negedge clk);
        mtr_vld_r = 1'b1; mtr_accept = 1'b1; mtr_gnt = 4'b0100;
        cmd_vld_r = 1'b1;
        #1;
        exp_q.push_back(4'b0100);
        pop_check("hole_dl", dl_vld);
        exp_q.push_back(4'b0000);
        pop_check("hole_no_al_when_full", al_vld);
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if ({busy_r, cnt_r, full_r} !== {4'b1011, 3'd3, 1'b0}) begin
            errors++;
            $display("FAIL hole_state: busy=%b cnt=%0d full=%b required 1011 3 0", busy_r, cnt_r, full_r);
        end
        cmd_vld_r = 1'b1;
        #1;
        exp_q.push_back(4'b0100);
        pop_check("hole_al", al_vld);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        mtr_vld_r = 1'b1; mtr_accept = 1'b1; mtr_gnt = 4'b0001;
        cncl_vld = 1'b1; cncl_slot = 2'd3;
        #1;
        exp_q.push_back(4'b1001);
        pop_check("simul_dl", dl_vld);
        @(negedge clk);
        idle_inputs();
        checks++;
        if ({busy_r, cnt_r} !== {4'b0110, 3'd2}) begin
            errors++;
            $display("FAIL simul_state: busy=%b cnt=%0d required 0110 2", busy_r, cnt_r);
        end
        mtr_vld_r = 1'b1; mtr_accept = 1'b1; mtr_gnt = 4'b0010;
        cncl_vld = 1'b1; cncl_slot = 2'd1;
        #1;
        exp_q.push_back(4'b0010);
        pop_check("same_slot_dl", dl_vld);
        @(negedge clk);
        idle_inputs();
        checks++;
        if ({busy_r, cnt_r, cncl_err_r} !== {4'b0100, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL same_slot_state: busy=%b cnt=%0d err=%b required 0100 1 0", busy_r, cnt_r, cncl_err_r);
        end
    endtask

    task automatic test_bad_cancel();
        apply_reset();
        install_n(1);
        cncl_vld = 1'b1; cncl_slot = 2'd2;
        #1;
        exp_q.push_back(4'b0000);
        pop_check("bad_cncl_dl", dl_vld);
        checks++;
        if (cncl_err_r !== 1'b0) begin
            errors++;
            $display("FAIL bad_cncl_pre: err=%b required 0", cncl_err_r);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
        end
        checks++;
        if ({cncl_err_r, busy_r, cnt_r} !== {1'b1, 4'b0001, 3'd1}) begin
            errors++;
            $display("FAIL bad_cncl_sticky: err=%b busy=%b cnt=%0d required 1 0001 1", cncl_err_r, busy_r, cnt_r);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        install_n(4);
        cncl_vld = 1'b1; cncl_slot = 2'd2;
        @(negedge clk);
        idle_inputs();
        flush_req = 1'b1;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1000);
        // flush_req held high through FLUSH must not restart the sequence.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            pop_check($sformatf("flush_dl_%0d", i), dl_vld);
            checks++;
            if ({state_dbg, cmd_rdy, flush_done_r} !== {S_FLUSH, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL flush_phase_%0d: state=%0d rdy=%b done=%b required 1 0 0", i, state_dbg, cmd_rdy, flush_done_r);
            end
        end
        @(negedge clk);
        flush_req = 1'b0;
        checks++;
        if ({flush_done_r, state_dbg, cmd_rdy, busy_r, empty_r} !== {1'b1, S_DONE, 1'b0, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL flush_done: done=%b state=%0d rdy=%b busy=%b empty=%b required 1 2 0 0000 1",
                     flush_done_r, state_dbg, cmd_rdy, busy_r, empty_r);
        end
        @(negedge clk);
        checks++;
        if ({flush_done_r, cmd_rdy} !== 2'b01) begin
            errors++;
            $display("FAIL flush_after: done=%b rdy=%b required 0 1", flush_done_r, cmd_rdy);
        end
        // Flush on an empty table.
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        checks++;
        if ({flush_done_r, state_dbg} !== {1'b0, S_FLUSH}) begin
            errors++;
            $display("FAIL empty_flush_t1: done=%b state=%0d required 0 1", flush_done_r, state_dbg);
        end
        @(negedge clk);
        checks++;
        if (flush_done_r !== 1'b1) begin
            errors++;
            $display("FAIL empty_flush_t2: done=%b required 1", flush_done_r);
        end
        @(negedge clk);
        checks++;
        if ({flush_done_r, cmd_rdy, state_dbg} !== {1'b0, 1'b1, S_RUN}) begin
            errors++;
            $display("FAIL empty_flush_t3: done=%b rdy=%b state=%0d required 0 1 0", flush_done_r, cmd_rdy, state_dbg);
        end
    endtask

    task automatic test_reset_mid_flush();
        apply_reset();
        install_n(3);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy_r, cnt_r, empty_r, full_r, state_dbg, dl_vld} !== {4'b0000, 3'd0, 1'b1, 1'b0, S_RUN, 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid_flush: busy=%b cnt=%0d empty=%b full=%b state=%0d dl=%b required 0000 0 1 0 0 0000",
                     busy_r, cnt_r, empty_r, full_r, state_dbg, dl_vld);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic [N-1:0] m_busy;
        logic [N-1:0] e_al;
        logic [N-1:0] e_dl;
        logic         m_err;
        int           j;
        int           n_busy;
        apply_reset();
        m_busy = '0;
        m_err  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            idle_inputs();
            cmd_vld_r = 1'($urandom_range(0, 1));
            if (m_busy != '0 && $urandom_range(0, 1) == 1) begin
                do j = $urandom_range(0, N - 1); while (!m_busy[j]);
                mtr_vld_r  = 1'b1;
                mtr_accept = 1'($urandom_range(0, 1));
                mtr_gnt    = '0;
                mtr_gnt[j] = 1'b1;
            end
            cncl_vld  = ($urandom_range(0, 3) == 0);
            cncl_slot = W'($urandom_range(0, N - 1));
            // Expected strobes from the model's busy map.
            n_busy = $countones(m_busy);
            e_al = '0;
            if (cmd_vld_r && n_busy < N) begin
                for (int k = N - 1; k >= 0; k--) if (!m_busy[k]) e_al = N'(1) << k;
            end
            e_dl = (mtr_vld_r && mtr_accept) ? mtr_gnt : '0;
            if (cncl_vld) begin
                if (m_busy[cncl_slot]) e_dl[cncl_slot] = 1'b1;
                else m_err = 1'b1;
            end
            #1;
            exp_q.push_back(e_al);
            pop_check("rand_al", al_vld);
            exp_q.push_back(e_dl);
            pop_check("rand_dl", dl_vld);
            m_busy = (m_busy & ~e_dl) | e_al;
            exp_q.push_back(m_busy);
            @(posedge clk);
            #1;
            pop_check("rand_busy", busy_r);
            n_busy = $countones(m_busy);
            checks++;
            if ({cnt_r, full_r, empty_r, cncl_err_r} !== {3'(n_busy), (n_busy == N), (n_busy == 0), m_err}) begin
                errors++;
                $display("FAIL rand_flags cyc %0d: cnt=%0d full=%b empty=%b err=%b required %0d %b %b %b",
                         c, cnt_r, full_r, empty_r, cncl_err_r, n_busy, (n_busy == N), (n_busy == 0), m_err);
            end
`ifdef OB_CN_ALLOC_AFULL_EN
            checks++;
            if (afull_r !== (n_busy >= N - 1)) begin
                errors++;
                $display("FAIL rand_afull cyc %0d: got %b required %b", c, afull_r, (n_busy >= N - 1));
            end
`endif
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hole_reuse();
        test_simultaneous();
        test_bad_cancel();
        test_flush();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
